// File: rtl/lsu_pkg.sv
// Shared definitions for the load/store unit: funct3 codes,
// FSM encoding and store lane helpers.
package lsu_pkg;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_ACCESS = 2'd1;
    localparam logic [1:0] ST_WAIT   = 2'd2;
    localparam logic [1:0] ST_RESP   = 2'd3;

    typedef enum logic [1:0] {
        S_IDLE   = ST_IDLE,
        S_ACCESS = ST_ACCESS,
        S_WAIT   = ST_WAIT,
        S_RESP   = ST_RESP
    } lsu_state_e;

    // Byte enables for a store of the given size at addr[1:0].
    function automatic logic [3:0] wmask(
        input logic [2:0] f3,
        input logic [1:0] a
    );
        logic [3:0] m;
        m = 4'b0000;
        case (f3)
            F3_B:    m = 4'b0001 << a;
            F3_H:    m = a[1] ? 4'b1100 : 4'b0011;
            F3_W:    m = 4'b1111;
            default: m = 4'b0000;
        endcase
        return m;
    endfunction

    // Replicate the right-aligned store data across all lanes.
    function automatic logic [31:0] wrepl(
        input logic [2:0]  f3,
        input logic [31:0] d
    );
        logic [31:0] r;
        r = d;
        case (f3)
            F3_B:    r = {4{d[7:0]}};
            F3_H:    r = {2{d[15:0]}};
            default: r = d;
        endcase
        return r;
    endfunction

    // Misaligned access or funct3 not legal for the direction.
    function automatic logic req_error(
        input logic       we,
        input logic [2:0] f3,
        input logic [1:0] a
    );
        logic e;
        e = 1'b1;
        case (f3)
            F3_B:    e = 1'b0;
            F3_H:    e = a[0];
            F3_W:    e = |a;
            F3_BU:   e = we;
            F3_HU:   e = we | a[0];
            default: e = 1'b1;
        endcase
        return e;
    endfunction

endpackage

// File: rtl/lsu_load_align.sv
// Load lane select and sign/zero extension from a
// 32-bit memory word.
module lsu_load_align
    import lsu_pkg::*;
(
    input  logic [31:0] rdata,
    input  logic [1:0]  addr,
    input  logic [2:0]  funct3,
    output logic [31:0] result
);

    logic [7:0]  b;
    logic [15:0] h;

    // Pick the addressed lane and extend it to 32 bits.
    always_comb begin
        b = rdata[7:0];
        case (addr)
            2'd0: b = rdata[7:0];
            2'd1: b = rdata[15:8];
            2'd2: b = rdata[23:16];
            2'd3: b = rdata[31:24];
            default: b = rdata[7:0];
        endcase
        h = addr[1] ? rdata[31:16] : rdata[15:0];
        case (funct3)
            F3_B:    result = {{24{b[7]}}, b};
            F3_H:    result = {{16{h[15]}}, h};
            F3_BU:   result = {24'h0, b};
            F3_HU:   result = {16'h0, h};
            default: result = rdata;
        endcase
    end

endmodule

// File: rtl/mem_lsu_master.sv
// Single-outstanding load/store master onto a word-addressed,
// byte-masked memory. Optional macro: LSU_BOUNDS_CHECK_EN.
module mem_lsu_master
    import lsu_pkg::*;
#(
    parameter int MEM_WORDS = 4096
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [2:0]  req_funct3,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        rsp_valid,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err,
    output logic        en_mem,
    output logic [31:0] mem_addr,
    output logic        mem_rstrb,
    output logic [31:0] mem_wdata,
    output logic [3:0]  mem_wmask,
    input  logic [31:0] mem_rdata
);

    lsu_state_e  state;
    logic        we_q;
    logic [2:0]  f3_q;
    logic [1:0]  a_q;
    logic [31:0] ld_data;
    logic        oob;
    logic        req_err;

    assign oob = {2'b00, req_addr[31:2]} >= 32'(MEM_WORDS);

`ifdef LSU_BOUNDS_CHECK_EN
    assign req_err = req_error(req_we, req_funct3, req_addr[1:0]) | oob;
`else
    logic oob_unused;
    assign oob_unused = oob;
    assign req_err = req_error(req_we, req_funct3, req_addr[1:0]);
`endif

    lsu_load_align u_align (
        .rdata  (mem_rdata),
        .addr   (a_q),
        .funct3 (f3_q),
        .result (ld_data)
    );

    // Request FSM; every output is a register updated here.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            state     <= S_IDLE;
            req_ready <= 1'b1;
            rsp_valid <= 1'b0;
            rsp_err   <= 1'b0;
            rsp_rdata <= 32'h0;
            en_mem    <= 1'b0;
            mem_rstrb <= 1'b0;
            mem_wmask <= 4'h0;
            mem_addr  <= 32'h0;
            mem_wdata <= 32'h0;
            we_q      <= 1'b0;
            f3_q      <= 3'h0;
            a_q       <= 2'h0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (req_valid) begin
                        we_q      <= req_we;
                        f3_q      <= req_funct3;
                        a_q       <= req_addr[1:0];
                        req_ready <= 1'b0;
                        if (req_err) begin
                            state     <= S_RESP;
                            rsp_valid <= 1'b1;
                            rsp_err   <= 1'b1;
                            rsp_rdata <= 32'h0;
                        end else begin
                            state     <= S_ACCESS;
                            en_mem    <= 1'b1;
                            mem_addr  <= {2'b00, req_addr[31:2]};
                            mem_rstrb <= ~req_we;
                            mem_wmask <= req_we ?
                                wmask(req_funct3, req_addr[1:0]) : 4'h0;
                            mem_wdata <= req_we ?
                                wrepl(req_funct3, req_wdata) : 32'h0;
                        end
                    end
                end
                S_ACCESS: begin
                    en_mem    <= 1'b0;
                    mem_rstrb <= 1'b0;
                    mem_wmask <= 4'h0;
                    if (we_q) begin
                        state     <= S_RESP;
                        rsp_valid <= 1'b1;
                        rsp_err   <= 1'b0;
                        rsp_rdata <= 32'h0;
                    end else begin
                        state <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    state     <= S_RESP;
                    rsp_valid <= 1'b1;
                    rsp_err   <= 1'b0;
                    rsp_rdata <= ld_data;
                end
                S_RESP: begin
                    state     <= S_IDLE;
                    rsp_valid <= 1'b0;
                    rsp_err   <= 1'b0;
                    rsp_rdata <= 32'h0;
                    req_ready <= 1'b1;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_lsu_master.sv
// Self-checking bench for mem_lsu_master with a registered
// byte-masked memory model and a response scoreboard.
module tb_mem_lsu_master;

    logic        clk = 1'b0;
    logic        resetn;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [2:0]  req_funct3;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        rsp_valid;
    logic [31:0] rsp_rdata;
    logic        rsp_err;
    logic        en_mem;
    logic [31:0] mem_addr;
    logic        mem_rstrb;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_wmask;
    logic [31:0] mem_rdata;

    int n_checks = 0;
    int n_fail   = 0;

    logic [32:0] sb[$];
    logic [31:0] mem [0:8191];

    typedef struct {
        int          lat;
        int          en_cyc;
        logic [31:0] ma;
        logic [3:0]  wm;
        logic [31:0] mwd;
        logic        rs;
        logic        rdy_after;
        logic        vld_after;
    } obs_t;

    mem_lsu_master #(.MEM_WORDS(4096)) dut (
        .clk        (clk),
        .resetn     (resetn),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_we     (req_we),
        .req_funct3 (req_funct3),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .rsp_valid  (rsp_valid),
        .rsp_rdata  (rsp_rdata),
        .rsp_err    (rsp_err),
        .en_mem     (en_mem),
        .mem_addr   (mem_addr),
        .mem_rstrb  (mem_rstrb),
        .mem_wdata  (mem_wdata),
        .mem_wmask  (mem_wmask),
        .mem_rdata  (mem_rdata)
    );

    always #5 clk = ~clk;

    // Registered memory: read data valid the cycle after en_mem.
    always @(posedge clk) begin
        if (en_mem) begin
            for (int b = 0; b < 4; b++)
                if (mem_wmask[b])
                    mem[mem_addr[12:0]][8*b +: 8] <= mem_wdata[8*b +: 8];
            mem_rdata <= mem[mem_addr[12:0]];
        end
    end

    // Scoreboard: every response must match the oldest expectation.
    always @(negedge clk) begin
        if (resetn === 1'b1 && rsp_valid === 1'b1) begin
            n_checks++;
            if (sb.size() == 0) begin
                n_fail++;
                $display("FAIL rsp_unexpected: got err=%0b rdata=%h, expected no response",
                         rsp_err, rsp_rdata);
            end else begin
                logic [32:0] e;
                e = sb.pop_front();
                if ({rsp_err, rsp_rdata} !== e) begin
                    n_fail++;
                    $display("FAIL rsp_data: got err=%0b rdata=%h, expected err=%0b rdata=%h",
                             rsp_err, rsp_rdata, e[32], e[31:0]);
                end
            end
        end
    end

    // Drive one request from IDLE and record what the port does.
    task automatic run_req(
        input  logic        we,
        input  logic [2:0]  f3,
        input  logic [31:0] a,
        input  logic [31:0] wd,
        output obs_t        o
    );
        o.lat = -2; o.en_cyc = -1;
        o.ma = 'x; o.wm = 'x; o.mwd = 'x; o.rs = 'x;
        o.rdy_after = 1'b0; o.vld_after = 1'b1;
        for (int w = 0; w < 10 && req_ready !== 1'b1; w++) begin
            @(posedge clk); #1;
        end
        if (req_ready !== 1'b1) return;
        req_valid = 1'b1; req_we = we; req_funct3 = f3;
        req_addr = a; req_wdata = wd;
        @(posedge clk); #1;
        req_valid = 1'b0;
        o.lat = -1;
        for (int c = 1; c <= 8; c++) begin
            if (en_mem === 1'b1 && o.en_cyc < 0) begin
                o.en_cyc = c; o.ma = mem_addr; o.wm = mem_wmask;
                o.mwd = mem_wdata; o.rs = mem_rstrb;
            end
            if (rsp_valid === 1'b1) begin
                o.lat = c;
                break;
            end
            @(posedge clk); #1;
        end
        @(posedge clk); #1;
        o.rdy_after = req_ready;
        o.vld_after = rsp_valid;
    endtask

    task automatic test_reset();
        resetn = 1'b0; req_valid = 1'b0; req_we = 1'b0;
        req_funct3 = 3'b0; req_addr = 32'h0; req_wdata = 32'h0;
        repeat (3) @(posedge clk);
        #1;
        n_checks++;
        if (req_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_ready: got %b, expected 1", req_ready);
        end
        n_checks++;
        if ({rsp_valid, rsp_err, en_mem, mem_rstrb} !== 4'b0000) begin
            n_fail++;
            $display("FAIL reset_flags: got %b, expected 0000",
                     {rsp_valid, rsp_err, en_mem, mem_rstrb});
        end
        n_checks++;
        if ({rsp_rdata, mem_addr, mem_wdata, mem_wmask} !== 100'h0) begin
            n_fail++;
            $display("FAIL reset_data: got rdata=%h addr=%h wdata=%h mask=%b, expected 0",
                     rsp_rdata, mem_addr, mem_wdata, mem_wmask);
        end
        resetn = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_store_word();
        obs_t o;
        sb.push_back({1'b0, 32'h0});
        run_req(1'b1, 3'b010, 32'h100, 32'hDEADBEEF, o);
        n_checks++;
        if (o.en_cyc !== 1 || o.lat !== 2) begin
            n_fail++;
            $display("FAIL sw_timing: got en=%0d rsp=%0d, expected en=1 rsp=2",
                     o.en_cyc, o.lat);
        end
        n_checks++;
        if (o.ma !== 32'h40 || o.wm !== 4'hF || o.mwd !== 32'hDEADBEEF || o.rs !== 1'b0) begin
            n_fail++;
            $display("FAIL sw_port: got addr=%h mask=%b wdata=%h rstrb=%b, expected 40 1111 deadbeef 0",
                     o.ma, o.wm, o.mwd, o.rs);
        end
        n_checks++;
        if (o.rdy_after !== 1'b1 || o.vld_after !== 1'b0) begin
            n_fail++;
            $display("FAIL sw_after: got ready=%b valid=%b, expected ready=1 valid=0",
                     o.rdy_after, o.vld_after);
        end
    endtask

    task automatic test_store_byte();
        obs_t o;
        sb.push_back({1'b0, 32'h0});
        run_req(1'b1, 3'b000, 32'h103, 32'h000000A5, o);
        n_checks++;
        if (o.wm !== 4'b1000 || o.mwd !== 32'hA5A5A5A5 || o.lat !== 2) begin
            n_fail++;
            $display("FAIL sb_port: got mask=%b wdata=%h rsp=%0d, expected 1000 a5a5a5a5 2",
                     o.wm, o.mwd, o.lat);
        end
    endtask

    task automatic test_load_byte();
        obs_t o;
        sb.push_back({1'b0, 32'hFFFFFFA5});
        run_req(1'b0, 3'b000, 32'h103, 32'h0, o);
        n_checks++;
        if (o.lat !== 3 || o.en_cyc !== 1 || o.rs !== 1'b1 || o.wm !== 4'h0 || o.ma !== 32'h40) begin
            n_fail++;
            $display("FAIL lb_port: got rsp=%0d en=%0d rstrb=%b mask=%b addr=%h, expected 3 1 1 0000 40",
                     o.lat, o.en_cyc, o.rs, o.wm, o.ma);
        end
        sb.push_back({1'b0, 32'h000000A5});
        run_req(1'b0, 3'b100, 32'h103, 32'h0, o);
        n_checks++;
        if (o.lat !== 3) begin
            n_fail++;
            $display("FAIL lbu_timing: got rsp=%0d, expected 3", o.lat);
        end
    endtask

    task automatic test_load_half();
        obs_t o;
        sb.push_back({1'b0, 32'h0});
        run_req(1'b1, 3'b010, 32'h100, 32'h80011234, o);
        sb.push_back({1'b0, 32'hFFFF8001});
        run_req(1'b0, 3'b001, 32'h102, 32'h0, o);
        sb.push_back({1'b0, 32'h00008001});
        run_req(1'b0, 3'b101, 32'h102, 32'h0, o);
        sb.push_back({1'b0, 32'h00001234});
        run_req(1'b0, 3'b001, 32'h100, 32'h0, o);
        sb.push_back({1'b0, 32'h00000012});
        run_req(1'b0, 3'b000, 32'h101, 32'h0, o);
        sb.push_back({1'b0, 32'h0});
        run_req(1'b1, 3'b001, 32'h102, 32'h0000BEEF, o);
        n_checks++;
        if (o.wm !== 4'b1100 || o.mwd !== 32'hBEEFBEEF) begin
            n_fail++;
            $display("FAIL sh_hi_port: got mask=%b wdata=%h, expected 1100 beefbeef",
                     o.wm, o.mwd);
        end
        sb.push_back({1'b0, 32'h0});
        run_req(1'b1, 3'b001, 32'h100, 32'hFFFF5678, o);
        n_checks++;
        if (o.wm !== 4'b0011 || o.mwd !== 32'h56785678) begin
            n_fail++;
            $display("FAIL sh_lo_port: got mask=%b wdata=%h, expected 0011 56785678",
                     o.wm, o.mwd);
        end
        sb.push_back({1'b0, 32'hBEEF5678});
        run_req(1'b0, 3'b010, 32'h100, 32'h0, o);
    endtask

    task automatic test_errors();
        logic [35:0] tbl [7];
        obs_t o;
        tbl[0] = {1'b0, 3'b010, 32'h101};
        tbl[1] = {1'b0, 3'b011, 32'h100};
        tbl[2] = {1'b1, 3'b001, 32'h101};
        tbl[3] = {1'b1, 3'b100, 32'h100};
        tbl[4] = {1'b0, 3'b101, 32'h103};
        tbl[5] = {1'b0, 3'b111, 32'h100};
        tbl[6] = {1'b1, 3'b010, 32'h102};
        for (int i = 0; i < 7; i++) begin
            sb.push_back({1'b1, 32'h0});
            run_req(tbl[i][35], tbl[i][34:32], tbl[i][31:0], 32'h12345678, o);
            n_checks++;
            if (o.lat !== 1 || o.en_cyc !== -1) begin
                n_fail++;
                $display("FAIL err_%0d: got rsp=%0d en=%0d, expected rsp=1 en=-1",
                         i, o.lat, o.en_cyc);
            end
        end
    endtask

    task automatic test_reset_mid();
        obs_t o;
        req_valid = 1'b1; req_we = 1'b0; req_funct3 = 3'b010;
        req_addr = 32'h100; req_wdata = 32'h0;
        @(posedge clk); #1;
        req_valid = 1'b0;
        @(posedge clk); #1;
        resetn = 1'b0;
        @(posedge clk); #1;
        n_checks++;
        if (rsp_valid !== 1'b0 || req_ready !== 1'b1 || en_mem !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_mid: got valid=%b ready=%b en=%b, expected 0 1 0",
                     rsp_valid, req_ready, en_mem);
        end
        resetn = 1'b1;
        @(posedge clk); #1;
        sb.push_back({1'b0, 32'h0});
        run_req(1'b1, 3'b010, 32'h200, 32'hCAFEF00D, o);
        n_checks++;
        if (o.lat !== 2 || o.ma !== 32'h80 || o.mwd !== 32'hCAFEF00D) begin
            n_fail++;
            $display("FAIL reset_mid_sw: got rsp=%0d addr=%h wdata=%h, expected 2 80 cafef00d",
                     o.lat, o.ma, o.mwd);
        end
    endtask

    task automatic test_bounds();
        obs_t o;
`ifdef LSU_BOUNDS_CHECK_EN
        sb.push_back({1'b1, 32'h0});
        run_req(1'b0, 3'b010, 32'h4000, 32'h0, o);
        n_checks++;
        if (o.lat !== 1 || o.en_cyc !== -1) begin
            n_fail++;
            $display("FAIL bounds: got rsp=%0d en=%0d, expected rsp=1 en=-1",
                     o.lat, o.en_cyc);
        end
`else
        sb.push_back({1'b0, 32'h0});
        run_req(1'b0, 3'b010, 32'h4000, 32'h0, o);
        n_checks++;
        if (o.lat !== 3 || o.en_cyc !== 1 || o.ma !== 32'h1000) begin
            n_fail++;
            $display("FAIL bounds: got rsp=%0d en=%0d addr=%h, expected 3 1 1000",
                     o.lat, o.en_cyc, o.ma);
        end
`endif
        sb.push_back({1'b0, 32'h0});
        run_req(1'b1, 3'b010, 32'h3FFC, 32'h0BADCAFE, o);
        sb.push_back({1'b0, 32'h0BADCAFE});
        run_req(1'b0, 3'b010, 32'h3FFC, 32'h0, o);
        n_checks++;
        if (o.lat !== 3 || o.ma !== 32'hFFF) begin
            n_fail++;
            $display("FAIL bounds_last: got rsp=%0d addr=%h, expected 3 fff",
                     o.lat, o.ma);
        end
    endtask

    task automatic test_back_to_back();
        obs_t o;
        for (int i = 0; i < 4; i++) begin
            logic [31:0] d;
            d = $urandom;
            sb.push_back({1'b0, 32'h0});
            run_req(1'b1, 3'b010, 32'h300 + 32'(4 * i), d, o);
            sb.push_back({1'b0, {{24{d[15]}}, d[15:8]}});
            run_req(1'b0, 3'b000, 32'h301 + 32'(4 * i), 32'h0, o);
            n_checks++;
            if (o.lat !== 3 || o.rdy_after !== 1'b1) begin
                n_fail++;
                $display("FAIL b2b_%0d: got rsp=%0d ready=%b, expected 3 1",
                         i, o.lat, o.rdy_after);
            end
        end
    endtask

    initial begin
        for (int i = 0; i < 8192; i++) mem[i] = 32'h0;
        mem_rdata = 32'h0;
        test_reset();
        test_store_word();
        test_store_byte();
        test_load_byte();
        test_load_half();
        test_errors();
        test_reset_mid();
        test_bounds();
        test_back_to_back();
        repeat (3) @(posedge clk);
        #1;
        n_checks++;
        if (sb.size() != 0) begin
            n_fail++;
            $display("FAIL sb_drain: got %0d pending responses, expected 0", sb.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule
